fpu_stream_master: RTL
======================

// Module: fpu_stream_master
// PURPOSE
// Initiator side of the stb/ack operand/result protocol used by the serial FPU cores (e.g. the multiplier).
// Buffers operand pairs from a valid/ready stream and presents them to the FPU as A then B.
// Collects each result Z and returns it in order on a valid/ready result stream.
// Sits between the matrix-multiplier datapath sequencer and one FPU instance; exactly one op in flight.
// PARAMETERS
// OP_DEPTH   4   operand-pair FIFO depth (power of 2, >=2)
// RES_DEPTH  4   result FIFO depth (power of 2, >=2)
// TIMEOUT    256 watchdog limit in cycles per handshake phase; 0 disables watchdog
// CNT_W      16  width of completed-op counter
// PORTS
// clk          in  1      clock
// rst          in  1      synchronous active-high reset (also drives the attached FPU rst)
// op_a         in  32     IEEE-754 single operand A
// op_b         in  32     IEEE-754 single operand B
// op_valid     in  1      operand pair valid
// op_ready     out 1      operand FIFO not full
// res_data     out 32     result word (FIFO head, show-ahead)
// res_valid    out 1      result FIFO not empty
// res_ready    in  1      downstream consumes result
// fpu_a        out 32     operand A to FPU input_a
// fpu_a_stb    out 1      to FPU input_a_stb
// fpu_a_ack    in  1      from FPU input_a_ack
// fpu_b        out 32     operand B to FPU input_b
// fpu_b_stb    out 1      to FPU input_b_stb
// fpu_b_ack    in  1      from FPU input_b_ack
// fpu_z        in  32     from FPU output_z
// fpu_z_stb    in  1      from FPU output_z_stb
// fpu_z_ack    out 1      to FPU output_z_ack
// busy         out 1      state != IDLE
// timeout_err  out 1      sticky watchdog flag
// op_count     out CNT_W  completed ops, wraps at 2^CNT_W
// BEHAVIOUR
// - Reset: all stb/ack outputs 0, fpu_a/fpu_b 0, FIFOs empty (op_ready=1, res_valid=0), busy=0, timeout_err=0, op_count=0, state IDLE.
//   Reset mid-operation discards the in-flight op and all queued ops/results; no partial handshake survives.
// - Transfer rule: a beat moves on a rising edge where stb && ack; the stb side holds data and stb until then.
//   ack may already be high when stb rises.
// - Operand FIFO: push on op_valid && op_ready; op_ready = !full only (no bypass when full, even if popping same cycle).
// - Result FIFO: push on Z beat; pop on res_valid && res_ready; simultaneous push/pop legal at any level.
// - FSM (all outputs registered):
//   IDLE:   if op FIFO non-empty AND res FIFO count + 0 < RES_DEPTH -> pop into fpu_a/fpu_b, fpu_a_stb<=1, ->SEND_A.
//           Reserving a result slot at launch guarantees Z is never refused.
//   SEND_A: on fpu_a_stb && fpu_a_ack -> fpu_a_stb<=0, fpu_b_stb<=1, ->SEND_B.
//   SEND_B: on fpu_b_stb && fpu_b_ack -> fpu_b_stb<=0, fpu_z_ack<=1, ->WAIT_Z.
//   WAIT_Z: on fpu_z_stb && fpu_z_ack -> push fpu_z, fpu_z_ack<=0, op_count++, ->IDLE.
// - Latency: op pushed at edge T into an idle/empty block -> pop at T+1, fpu_a_stb high after T+1.
//   res_valid high the cycle after the Z beat edge.
// - Throughput: one op per (3 handshakes + FPU compute + 1 IDLE cycle); IDLE never skipped.
// - Ordering: results leave strictly in operand-arrival order.
// - Watchdog: phase counter clears on every state entry and counts in SEND_A/SEND_B/WAIT_Z.
//   When it reaches TIMEOUT (TIMEOUT!=0), timeout_err<=1 (sticky until rst).
//   FSM does NOT abort, it keeps waiting (protocol integrity). Counter saturates.
// - fpu_a/fpu_b values hold from launch until next launch; never change while a stb is high.
// TESTING
// - op 0x3F800000 x 0x40000000 with real FPU -> res_data 0x40000000; op_count 1; busy back to 0.
// - 6 ops back-to-back, res_ready=0, RES_DEPTH=4 -> exactly 4 results queued, 5th not launched (fpu_a_stb stays 0).
//   Op FIFO fills, op_ready=0. Release res_ready -> all 6 results in order.
// - FPU model holding fpu_b_ack=0, TIMEOUT=16 -> timeout_err rises after 16 cycles in SEND_B; fpu_b_stb stays 1.
//   Later ack completes the op normally.
// - FPU model with acks tied high -> each phase completes on first stb cycle.
//   Random res_ready stalls -> no lost/duplicated results over 100 ops.
// - rst asserted in WAIT_Z with 2 ops queued and 1 result pending -> next cycle all outputs at reset values.
//   A new op then completes correctly.

Source files
------------

// File: rtl/fpu_stream_master.sv
`default_nettype none
// ============================================================================
// Module      : fpu_stream_master
// Description : Initiator side of the stb/ack operand/result protocol used by
//               the serial FPU cores. Operand pairs arrive on a valid/ready
//               stream and are buffered. Each pair is presented to the FPU as
//               A, then B. Each result Z is collected and returned in order on
//               a valid/ready result stream. Exactly one op is in flight.
// Ports       : clk, rst                     clock, sync active-high reset
//               op_a/op_b/op_valid/op_ready  operand pair stream in
//               res_data/res_valid/res_ready result stream out (show-ahead)
//               fpu_a*/fpu_b*/fpu_z*         stb/ack links to one FPU core
//               busy, timeout_err, op_count  status
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_stream_master #(
    parameter int OP_DEPTH  = 4,
    parameter int RES_DEPTH = 4,
    parameter int TIMEOUT   = 256,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [31:0]      res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      fpu_a,
    output logic             fpu_a_stb,
    input  logic             fpu_a_ack,
    output logic [31:0]      fpu_b,
    output logic             fpu_b_stb,
    input  logic             fpu_b_ack,
    input  logic [31:0]      fpu_z,
    input  logic             fpu_z_stb,
    output logic             fpu_z_ack,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] op_count
);

    localparam int c_op_aw  = $clog2(OP_DEPTH);
    localparam int c_res_aw = $clog2(RES_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND_A = 2'd1,
        S_SEND_B = 2'd2,
        S_WAIT_Z = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------
    // Operand FIFO: pointers carry one extra wrap bit to tell full/empty.
    // ------------------------------------------------------------------
    logic [63:0]        r_op_mem [OP_DEPTH];
    logic [c_op_aw:0]   r_op_wr;
    logic [c_op_aw:0]   r_op_rd;
    logic               w_op_empty;
    logic               w_op_full;
    logic               w_op_push;
    logic               w_launch;

    assign w_op_empty = (r_op_wr == r_op_rd);
    assign w_op_full  = (r_op_wr[c_op_aw] != r_op_rd[c_op_aw]) &&
                        (r_op_wr[c_op_aw-1:0] == r_op_rd[c_op_aw-1:0]);
    // No bypass: a full FIFO refuses input even if the head pops this cycle.
    assign op_ready   = !w_op_full;
    assign w_op_push  = op_valid && !w_op_full;

    always_ff @(posedge clk) begin
        if (w_op_push) begin
            r_op_mem[r_op_wr[c_op_aw-1:0]] <= {op_a, op_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_wr <= '0;
            r_op_rd <= '0;
        end else begin
            if (w_op_push) r_op_wr <= r_op_wr + 1'b1;
            if (w_launch)  r_op_rd <= r_op_rd + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic [31:0]        r_res_mem [RES_DEPTH];
    logic [c_res_aw:0]  r_res_wr;
    logic [c_res_aw:0]  r_res_rd;
    logic               w_res_full;
    logic               w_res_pop;
    logic               w_z_beat;

    assign res_valid  = (r_res_wr != r_res_rd);
    assign w_res_full = (r_res_wr[c_res_aw] != r_res_rd[c_res_aw]) &&
                        (r_res_wr[c_res_aw-1:0] == r_res_rd[c_res_aw-1:0]);
    assign res_data   = r_res_mem[r_res_rd[c_res_aw-1:0]];
    assign w_res_pop  = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (w_z_beat) begin
            r_res_mem[r_res_wr[c_res_aw-1:0]] <= fpu_z;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_wr <= '0;
            r_res_rd <= '0;
        end else begin
            if (w_z_beat)  r_res_wr <= r_res_wr + 1'b1;
            if (w_res_pop) r_res_rd <= r_res_rd + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM. A launch only happens while a result slot is free;
    // with a single op in flight that slot stays reserved, so the Z beat
    // can always be accepted.
    // ------------------------------------------------------------------
    logic r_a_stb;
    logic r_b_stb;
    logic r_z_ack;

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_z_beat    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_op_empty && !w_res_full) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_SEND_A;
                end
            end
            S_SEND_A: if (r_a_stb && fpu_a_ack) w_state_nxt = S_SEND_B;
            S_SEND_B: if (r_b_stb && fpu_b_ack) w_state_nxt = S_WAIT_Z;
            S_WAIT_Z: begin
                if (fpu_z_stb && r_z_ack) begin
                    w_z_beat    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    logic [31:0]      r_fpu_a;
    logic [31:0]      r_fpu_b;
    logic [CNT_W-1:0] r_op_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_a_stb    <= 1'b0;
            r_b_stb    <= 1'b0;
            r_z_ack    <= 1'b0;
            r_fpu_a    <= '0;
            r_fpu_b    <= '0;
            r_op_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Strobes follow the next state so each is a clean flop output.
            r_a_stb <= (w_state_nxt == S_SEND_A);
            r_b_stb <= (w_state_nxt == S_SEND_B);
            r_z_ack <= (w_state_nxt == S_WAIT_Z);
            if (w_launch) begin
                {r_fpu_a, r_fpu_b} <= r_op_mem[r_op_rd[c_op_aw-1:0]];
            end
            if (w_z_beat) r_op_count <= r_op_count + 1'b1;
        end
    end

    assign fpu_a     = r_fpu_a;
    assign fpu_b     = r_fpu_b;
    assign fpu_a_stb = r_a_stb;
    assign fpu_b_stb = r_b_stb;
    assign fpu_z_ack = r_z_ack;
    assign busy      = (r_state != S_IDLE);
    assign op_count  = r_op_count;

    // ------------------------------------------------------------------
    // Watchdog: flags a stuck phase but never aborts it, so the FPU never
    // sees a handshake withdrawn half way.
    // ------------------------------------------------------------------
    logic w_timeout_err;

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int c_wd_w = $clog2(TIMEOUT + 1);
            localparam logic [c_wd_w-1:0] c_wd_max = TIMEOUT[c_wd_w-1:0];

            logic [c_wd_w-1:0] r_wd_cnt;
            logic              r_wd_err;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wd_cnt <= '0;
                    r_wd_err <= 1'b0;
                end else if (w_state_nxt != r_state) begin
                    r_wd_cnt <= '0;
                end else if (r_state != S_IDLE && r_wd_cnt != c_wd_max) begin
                    r_wd_cnt <= r_wd_cnt + 1'b1;
                    if (r_wd_cnt == c_wd_max - 1'b1) r_wd_err <= 1'b1;
                end
            end

            assign w_timeout_err = r_wd_err;
        end else begin : g_no_wd
            assign w_timeout_err = 1'b0;
        end
    endgenerate

    assign timeout_err = w_timeout_err;

endmodule
`default_nettype wire
